// File: rtl/cdc_async_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  cdc_async_fifo
//  Gray-pointer asynchronous FIFO with a registered first-word-fall-through
//  output stage, per-side fill levels and almost-full/almost-empty flags.
//  Revision: 1.0
// ============================================================================
module cdc_async_fifo #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AF_MARGIN   = 1,
   parameter int AE_MARGIN   = 1
) (
   input  logic                  src_clk,
   input  logic                  src_rst_n,
   input  logic                  dst_clk,
   input  logic                  dst_rst_n,
   input  logic [DATA_WIDTH-1:0] src_data,
   input  logic                  src_valid,
   output logic                  src_ready,
   output logic [ADDR_WIDTH:0]   src_level,
   output logic                  src_almost_full,
   output logic [DATA_WIDTH-1:0] dst_data,
   output logic                  dst_valid,
   input  logic                  dst_ready,
   output logic [ADDR_WIDTH:0]   dst_level,
   output logic                  dst_almost_empty
);

   localparam int              DEPTH    = 1 << ADDR_WIDTH;
   localparam int              PW       = ADDR_WIDTH + 1;
   localparam logic [PW-1:0]   AF_LEVEL = PW'(DEPTH - AF_MARGIN);
   localparam logic [PW-1:0]   AE_LEVEL = PW'(AE_MARGIN);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // ---------------- source domain ----------------
   logic [PW-1:0]                  wptr_bin_q,  wptr_bin_d;
   logic [PW-1:0]                  wptr_gray_q, wptr_gray_d;
   logic [SYNC_STAGES-1:0][PW-1:0] rsync_q,     rsync_d;
   logic [PW-1:0]                  src_level_q, src_level_d;
   logic                           src_af_q,    src_af_d;
   logic                           full;
   logic                           wr_en;

   // ---------------- destination domain ----------------
   logic [PW-1:0]                  rptr_bin_q,  rptr_bin_d;
   logic [PW-1:0]                  rptr_gray_q, rptr_gray_d;
   logic [SYNC_STAGES-1:0][PW-1:0] wsync_q,     wsync_d;
   logic [DATA_WIDTH-1:0]          dst_data_q,  dst_data_d;
   logic                           dst_valid_q, dst_valid_d;
   logic [PW-1:0]                  dst_level_q, dst_level_d;
   logic                           dst_ae_q,    dst_ae_d;
   logic                           empty;
   logic                           load;

   // Full when the pointers differ by exactly DEPTH: in gray that is the
   // top two bits inverted and the rest equal.
   always_comb begin
      full        = (wptr_gray_q == {~rsync_q[SYNC_STAGES-1][PW-1:PW-2],
                                     rsync_q[SYNC_STAGES-1][PW-3:0]});
      wr_en       = src_valid && !full;
      wptr_bin_d  = wptr_bin_q + PW'(wr_en);
      wptr_gray_d = bin2gray(wptr_bin_d);
      rsync_d     = {rsync_q[SYNC_STAGES-2:0], rptr_gray_q};
      src_level_d = wptr_bin_d - gray2bin(rsync_d[SYNC_STAGES-1]);
      src_af_d    = (src_level_d >= AF_LEVEL);
   end

   always_ff @(posedge src_clk or negedge src_rst_n) begin
      if (!src_rst_n) begin
         wptr_bin_q  <= '0;
         wptr_gray_q <= '0;
         rsync_q     <= '0;
         src_level_q <= '0;
         src_af_q    <= 1'b0;
      end else begin
         wptr_bin_q  <= wptr_bin_d;
         wptr_gray_q <= wptr_gray_d;
         rsync_q     <= rsync_d;
         src_level_q <= src_level_d;
         src_af_q    <= src_af_d;
      end
   end

   always_ff @(posedge src_clk) begin
      if (wr_en) begin
         mem_q[wptr_bin_q[ADDR_WIDTH-1:0]] <= src_data;
      end
   end

   // The output register refills whenever it is free or being consumed.
   always_comb begin
      wsync_d     = {wsync_q[SYNC_STAGES-2:0], wptr_gray_q};
      empty       = (rptr_gray_q == wsync_q[SYNC_STAGES-1]);
      load        = (!dst_valid_q || dst_ready) && !empty;
      rptr_bin_d  = rptr_bin_q;
      dst_data_d  = dst_data_q;
      dst_valid_d = dst_valid_q;
      if (load) begin
         dst_data_d  = mem_q[rptr_bin_q[ADDR_WIDTH-1:0]];
         dst_valid_d = 1'b1;
         rptr_bin_d  = rptr_bin_q + PW'(1);
      end else if (dst_ready) begin
         dst_valid_d = 1'b0;
      end
      rptr_gray_d = bin2gray(rptr_bin_d);
      dst_level_d = gray2bin(wsync_d[SYNC_STAGES-1]) - rptr_bin_d;
      dst_ae_d    = (dst_level_d <= AE_LEVEL);
   end

   always_ff @(posedge dst_clk or negedge dst_rst_n) begin
      if (!dst_rst_n) begin
         rptr_bin_q  <= '0;
         rptr_gray_q <= '0;
         wsync_q     <= '0;
         dst_data_q  <= '0;
         dst_valid_q <= 1'b0;
         dst_level_q <= '0;
         dst_ae_q    <= 1'b1;
      end else begin
         rptr_bin_q  <= rptr_bin_d;
         rptr_gray_q <= rptr_gray_d;
         wsync_q     <= wsync_d;
         dst_data_q  <= dst_data_d;
         dst_valid_q <= dst_valid_d;
         dst_level_q <= dst_level_d;
         dst_ae_q    <= dst_ae_d;
      end
   end

   assign src_ready        = !full;
   assign src_level        = src_level_q;
   assign src_almost_full  = src_af_q;
   assign dst_data         = dst_data_q;
   assign dst_valid        = dst_valid_q;
   assign dst_level        = dst_level_q;
   assign dst_almost_empty = dst_ae_q;

endmodule
`default_nettype wire
